sram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the shared single-port SRAM (16-bit word address, 32-bit data, 1-cycle registered read). Requester 0 (CPU) and requester 1 (DMA) issue read or write commands through a req/gnt handshake. The block registers the winning command onto the SRAM pins and routes the read data back to the owning requester with an rvalid strobe. It sustains one access per cycle.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_rr_pick.sv | 30 +++
 rtl/sram_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM arbiter: bus widths, requester IDs
// and the lock-ownership record.
package sram_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef struct packed {
        logic held;
        logic id;
    } lock_t;

    localparam lock_t LOCK_NONE = '{held: 1'b0, id: 1'b0};

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin picker: the requester other than `last` wins a tie,
// and a held lock restricts the grant to the lock owner alone.
module sram_rr_pick
    import sram_pkg::lock_t;
    import sram_pkg::REQ_CPU;
    import sram_pkg::REQ_DMA;
(
    input  logic [1:0] req,
    input  logic       last,
    input  lock_t      lock_owner,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: gnt is given a value before any branch so no path leaves it unassigned (no latch).
        gnt = 2'b00;
        if (lock_owner.held) begin
            if (lock_owner.id == REQ_DMA) gnt[1] = req[1];
            else                          gnt[0] = req[0];
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last == REQ_CPU) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port SRAM: registers
// the winning command onto the SRAM pins and steers read data back to its owner.
module sram_arbiter
    import sram_pkg::lock_t;
    import sram_pkg::LOCK_NONE;
    import sram_pkg::REQ_CPU;
#(
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int DATA_W = sram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] sram_ADDR,
    output logic [DATA_W-1:0] sram_DI,
    output logic              sram_EN,
    output logic              sram_WE,
    input  logic [DATA_W-1:0] sram_DO
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              gnt_any;
    logic              gnt_id;
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_di_q,   sram_di_d;
    logic              sram_en_q,   sram_en_d;
    logic              sram_we_q,   sram_we_d;
    logic              last_q,      last_d;
    lock_t             lock_q,      lock_d;
    logic              cmd_owner_q, cmd_owner_d;
    logic              cmd_rd_q,    cmd_rd_d;
    logic              rd_owner_q,  rd_owner_d;
    logic              rd_valid_q,  rd_valid_d;

    assign req = {m1_req, m0_req};

    sram_rr_pick u_pick (
        .req        (req),
        .last       (last_q),
        .lock_owner (lock_q),
        .gnt        (gnt)
    );

    assign gnt_any   = |gnt;
    assign gnt_id    = gnt[1];
    assign sel_we    = gnt_id ? m1_we    : m0_we;
    assign sel_lock  = gnt_id ? m1_lock  : m0_lock;
    assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
    assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;

    always_comb begin
        sram_addr_d = sram_addr_q;
        sram_di_d   = sram_di_q;
        last_d      = last_q;
        lock_d      = lock_q;
        cmd_owner_d = cmd_owner_q;
        sram_en_d   = gnt_any;
        sram_we_d   = gnt_any & sel_we;
        cmd_rd_d    = gnt_any & ~sel_we;
        // Second stage lines up with sram_DO, one cycle after the command hits the pins.
        rd_valid_d  = cmd_rd_q;
        rd_owner_d  = cmd_owner_q;
        if (gnt_any) begin
            sram_addr_d = sel_addr;
            sram_di_d   = sel_wdata;
            last_d      = gnt_id;
            cmd_owner_d = gnt_id;
            lock_d      = sel_lock ? lock_t'{held: 1'b1, id: gnt_id} : LOCK_NONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_addr_q <= '0;
            sram_di_q   <= '0;
            sram_en_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            last_q      <= 1'b1;
            lock_q      <= LOCK_NONE;
            cmd_owner_q <= 1'b0;
            cmd_rd_q    <= 1'b0;
            rd_owner_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            sram_addr_q <= sram_addr_d;
            sram_di_q   <= sram_di_d;
            sram_en_q   <= sram_en_d;
            sram_we_q   <= sram_we_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            cmd_owner_q <= cmd_owner_d;
            cmd_rd_q    <= cmd_rd_d;
            rd_owner_q  <= rd_owner_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign sram_ADDR = sram_addr_q;
    assign sram_DI   = sram_di_q;
    assign sram_EN   = sram_en_q;
    assign sram_WE   = sram_we_q;

    assign m0_rvalid = rd_valid_q & (rd_owner_q == REQ_CPU);
    assign m1_rvalid = rd_valid_q & (rd_owner_q != REQ_CPU);
    assign m0_rdata  = m0_rvalid ? sram_DO : '0;
    assign m1_rdata  = m1_rvalid ? sram_DO : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, directed stimulus, and a scoreboard
// fed at grant time and drained by a response monitor.
module tb_sram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SWEEP_N = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] sram_ADDR;
    logic [DW-1:0] sram_DI, sram_DO;
    logic          sram_EN, sram_WE;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .sram_ADDR (sram_ADDR),
        .sram_DI   (sram_DI),
        .sram_EN   (sram_EN),
        .sram_WE   (sram_WE),
        .sram_DO   (sram_DO)
    );

    // Single-port SRAM with a registered read port.
    logic [DW-1:0] sram_mem [0:65535];
    always @(posedge clk) begin
        if (sram_EN === 1'b1) begin
            if (sram_WE) sram_mem[sram_ADDR] <= sram_DI;
            else         sram_DO <= sram_mem[sram_ADDR];
        end
    end

    typedef struct {
        bit            owner;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [0:65535];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic accept(input bit id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        if (we) begin
            ref_mem[a] = d;
        end else begin
            e.owner = id;
            e.data  = ref_mem[a];
            e.cyc   = cyc;
            sb.push_back(e);
        end
    endtask

    // Monitor: compare responses first, then log this cycle's grant.
    always @(negedge clk) begin
        exp_t e;
        if (m0_rvalid && m1_rvalid) check("dual_rvalid", 1, 0);
        if (m0_rvalid || m1_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", 64'(m1_rvalid), 64'(e.owner));
                check("rsp_data", m1_rvalid ? m1_rdata : m0_rdata, e.data);
                check("rsp_latency", 64'(cyc - e.cyc), 2);
            end
        end
        if (!reset && !m0_rvalid && m0_rdata !== '0) check("m0_rdata_idle", m0_rdata, 0);
        if (!reset && !m1_rvalid && m1_rdata !== '0) check("m1_rdata_idle", m1_rdata, 0);
        if (reset) begin
            sb.delete();
        end else begin
            if (m0_gnt && m1_gnt)   check("dual_gnt", 1, 0);
            if (m0_gnt && !m0_req)  check("m0_gnt_no_req", 1, 0);
            if (m1_gnt && !m1_req)  check("m1_gnt_no_req", 1, 0);
            if (m0_gnt)      accept(1'b0, m0_we, m0_addr, m0_wdata);
            else if (m1_gnt) accept(1'b1, m1_we, m1_addr, m1_wdata);
        end
    end

    task automatic set_m0(input logic rq, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = rq; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic rq, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = rq; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
    endtask

    task automatic idle();
        set_m0(0, 0, 0, '0, '0);
        set_m1(0, 0, 0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input string name, input logic g0, input logic g1);
        @(negedge clk);
        check({name, "_g0"}, m0_gnt, g0);
        check({name, "_g1"}, m1_gnt, g1);
    endtask

    function automatic logic [AW-1:0] sweep_addr(input int i);
        return (i < 256) ? AW'(i) : AW'(16'hFF00 + (i - 256));
    endfunction

    initial begin
        int w, r, budget;
        logic rd_ok;

        reset = 1'b1;
        idle();
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_en",    sram_EN, 0);
        check("rst_we",    sram_WE, 0);
        check("rst_addr",  sram_ADDR, 0);
        check("rst_di",    sram_DI, 0);
        check("rst_rv0",   m0_rvalid, 0);
        check("rst_rv1",   m1_rvalid, 0);
        tick();

        // Write then read back on requester 0.
        set_m0(1, 1, 0, 16'd5, 32'hA5A5_A5A5);
        expect_gnt("t1_wr", 1, 0);
        tick();
        set_m0(1, 0, 0, 16'd5, '0);
        expect_gnt("t1_rd", 1, 0);
        check("t1_pin_en",   sram_EN, 1);
        check("t1_pin_we",   sram_WE, 1);
        check("t1_pin_addr", sram_ADDR, 5);
        check("t1_pin_di",   sram_DI, 32'hA5A5_A5A5);
        tick();
        idle();
        @(negedge clk);
        check("t1_pin_rd_we", sram_WE, 0);
        check("t1_early_rv",  m0_rvalid, 0);
        tick();
        @(negedge clk);
        check("t1_rv0",   m0_rvalid, 1);
        check("t1_rdata", m0_rdata, 32'hA5A5_A5A5);
        check("t1_rv1",   m1_rvalid, 0);
        tick();

        // Preload, reset, then both requesters read continuously.
        set_m0(1, 1, 0, 16'd10, 32'h1010_1010);
        expect_gnt("t2_pre0", 1, 0);
        tick();
        set_m0(0, 0, 0, '0, '0);
        set_m1(1, 1, 0, 16'd20, 32'h2020_2020);
        expect_gnt("t2_pre1", 0, 1);
        tick();
        idle();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_m0(1, 0, 0, 16'd10, '0);
            set_m1(1, 0, 0, 16'd20, '0);
            expect_gnt("t2_rr", (i % 2) == 0, (i % 2) == 1);
            tick();
        end
        idle();
        repeat (3) tick();

        // Locked write by requester 1 starves requester 0 until lock is released.
        set_m1(1, 1, 1, 16'hFFFF, 32'h1234_5678);
        expect_gnt("t3_lockwr", 0, 1);
        tick();
        set_m1(0, 0, 0, '0, '0);
        set_m0(1, 0, 0, 16'd5, '0);
        expect_gnt("t3_starve_a", 0, 0);
        tick();
        expect_gnt("t3_starve_b", 0, 0);
        tick();
        set_m1(1, 0, 0, 16'hFFFF, '0);
        expect_gnt("t3_unlock", 0, 1);
        tick();
        set_m1(0, 0, 0, '0, '0);
        expect_gnt("t3_m0_after", 1, 0);
        tick();
        idle();
        repeat (3) tick();

        // Write followed immediately by a read of the same address from the other port.
        set_m0(1, 1, 0, 16'd3, 32'd7);
        expect_gnt("t4_wr", 1, 0);
        tick();
        set_m0(0, 0, 0, '0, '0);
        set_m1(1, 0, 0, 16'd3, '0);
        expect_gnt("t4_rd", 0, 1);
        tick();
        idle();
        tick();
        @(negedge clk);
        check("t4_rv1",   m1_rvalid, 1);
        check("t4_rdata", m1_rdata, 7);
        tick();
        repeat (2) tick();

        // Reset right after a read grant discards the read.
        set_m0(1, 0, 0, 16'd3, '0);
        expect_gnt("t5_rd", 1, 0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_en",    sram_EN, 0);
        check("t5_we",    sram_WE, 0);
        check("t5_addr",  sram_ADDR, 0);
        check("t5_di",    sram_DI, 0);
        check("t5_rv0",   m0_rvalid, 0);
        check("t5_rv1",   m1_rvalid, 0);
        check("t5_rd0",   m0_rdata, 0);
        check("t5_rd1",   m1_rdata, 0);
        check("t5_gnt",   {m1_gnt, m0_gnt}, 0);
        tick();
        set_m0(1, 0, 0, 16'd5, '0);
        set_m1(1, 0, 0, 16'd3, '0);
        expect_gnt("t5_tie", 1, 0);
        tick();
        set_m0(0, 0, 0, '0, '0);
        expect_gnt("t5_next", 0, 1);
        tick();
        idle();
        repeat (3) tick();

        // Sweep low and top address ranges: writes on 0, lagging reads on 1.
        w = 0;
        r = 0;
        budget = 0;
        while ((w < SWEEP_N || r < SWEEP_N) && budget < 4000) begin
            set_m0(w < SWEEP_N, 1, 0, sweep_addr(w), {16'h0, sweep_addr(w)});
            rd_ok = (r < SWEEP_N) && ((r + 2 <= w) || (w == SWEEP_N));
            set_m1(rd_ok, 0, 0, sweep_addr(r), '0);
            @(negedge clk);
            if (m0_gnt) w++;
            if (m1_gnt) r++;
            tick();
            budget++;
        end
        check("sweep_done", 64'((w == SWEEP_N) && (r == SWEEP_N)), 1);
        idle();
        repeat (4) tick();
        check("sb_drained", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
